// File: rtl/eth_tx_arb.sv
// Frame-granular two-port round-robin arbiter in front of the 10G MAC TX AXI-Stream port.
// A grant lasts from the first beat to the tlast beat. Per-port frame counters and a sticky oversize flag aid bring-up.
module eth_tx_arb #(
  parameter logic [15:0] MAX_BEATS  = 16'd190,
  parameter logic        FIRST_PRIO = 1'b0
) (
  input  logic        clk156,
  input  logic        reset,
  input  logic        s0_axis_tvalid,
  input  logic [63:0] s0_axis_tdata,
  input  logic [7:0]  s0_axis_tkeep,
  input  logic        s0_axis_tlast,
  output logic        s0_axis_tready,
  input  logic        s1_axis_tvalid,
  input  logic [63:0] s1_axis_tdata,
  input  logic [7:0]  s1_axis_tkeep,
  input  logic        s1_axis_tlast,
  output logic        s1_axis_tready,
  input  logic        m_axis_tx_tready,
  output logic        m_axis_tx_tvalid,
  output logic [63:0] m_axis_tx_tdata,
  output logic [7:0]  m_axis_tx_tkeep,
  output logic        m_axis_tx_tlast,
  output logic [31:0] frame_cnt0,
  output logic [31:0] frame_cnt1,
  output logic        oversize_err,
  output logic [1:0]  o_dbg_state
);

  // AXI-Stream handshake: a beat moves on a rising clk156 edge where tvalid and tready
  // are both high. A source holds tvalid and its data stable until that beat is accepted.
  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_P0   = 2'd1;
  localparam logic [1:0] ARB_P1   = 2'd2;

  logic [1:0]  r_state;
  logic        r_last_grant;
  logic [15:0] r_beat_cnt;
  logic [31:0] r_frame_cnt0;
  logic [31:0] r_frame_cnt1;
  logic        r_oversize;

  logic [1:0]  w_state_nxt;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_xfer;
  logic        w_xfer_last;
  logic [15:0] w_beat_next;

  // Gating with reset makes every ready and bus output zero during the reset cycle itself.
  assign w_gnt0 = (r_state == ARB_P0) && !reset;
  assign w_gnt1 = (r_state == ARB_P1) && !reset;

  always_comb begin
    m_axis_tx_tvalid = 1'b0;
    m_axis_tx_tdata  = '0;
    m_axis_tx_tkeep  = '0;
    m_axis_tx_tlast  = 1'b0;
    s0_axis_tready   = 1'b0;
    s1_axis_tready   = 1'b0;
    if (w_gnt0) begin
      m_axis_tx_tvalid = s0_axis_tvalid;
      m_axis_tx_tdata  = s0_axis_tdata;
      m_axis_tx_tkeep  = s0_axis_tkeep;
      m_axis_tx_tlast  = s0_axis_tlast;
      s0_axis_tready   = m_axis_tx_tready;
    end else if (w_gnt1) begin
      m_axis_tx_tvalid = s1_axis_tvalid;
      m_axis_tx_tdata  = s1_axis_tdata;
      m_axis_tx_tkeep  = s1_axis_tkeep;
      m_axis_tx_tlast  = s1_axis_tlast;
      s1_axis_tready   = m_axis_tx_tready;
    end
  end

  assign w_xfer      = m_axis_tx_tvalid && m_axis_tx_tready;
  assign w_xfer_last = w_xfer && m_axis_tx_tlast;
  assign w_beat_next = (r_beat_cnt == 16'hFFFF) ? r_beat_cnt : r_beat_cnt + 16'd1;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (s0_axis_tvalid && s1_axis_tvalid) w_state_nxt = r_last_grant ? ARB_P0 : ARB_P1;
        else if (s0_axis_tvalid)              w_state_nxt = ARB_P0;
        else if (s1_axis_tvalid)              w_state_nxt = ARB_P1;
      end
      ARB_P0, ARB_P1: begin
        if (w_xfer_last) w_state_nxt = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk156) begin
    if (reset) begin
      r_state      <= ARB_IDLE;
      r_last_grant <= ~FIRST_PRIO;
      r_beat_cnt   <= '0;
      r_frame_cnt0 <= '0;
      r_frame_cnt1 <= '0;
      r_oversize   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        r_beat_cnt <= w_xfer_last ? 16'd0 : w_beat_next;
        if (w_beat_next > MAX_BEATS) r_oversize <= 1'b1;
      end
      if (w_xfer_last) begin
        r_last_grant <= (r_state == ARB_P1);
        if (r_state == ARB_P0) r_frame_cnt0 <= r_frame_cnt0 + 32'd1;
        else                   r_frame_cnt1 <= r_frame_cnt1 + 32'd1;
      end
    end
  end

  assign frame_cnt0   = r_frame_cnt0;
  assign frame_cnt1   = r_frame_cnt1;
  assign oversize_err = r_oversize;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_eth_tx_arb.sv
// Bench for eth_tx_arb: queue-fed frame sources, a frame-level arbitration model and
// per-port beat scoreboards compared every cycle, plus literal checks per scenario.
module tb_eth_tx_arb;

  logic        clk156 = 1'b0;
  always #5 clk156 = ~clk156;

  logic        reset;
  logic        sv[2];
  logic [63:0] sd[2];
  logic [7:0]  sk[2];
  logic        sl[2];
  logic        s0_tready, s1_tready;
  logic        m_tready, m_tvalid, m_tlast;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic [31:0] frame_cnt0, frame_cnt1;
  logic        oversize_err;
  logic [1:0]  dbg_state;

  eth_tx_arb #(.MAX_BEATS(16'd190), .FIRST_PRIO(1'b0)) dut (
    .clk156(clk156), .reset(reset),
    .s0_axis_tvalid(sv[0]), .s0_axis_tdata(sd[0]), .s0_axis_tkeep(sk[0]),
    .s0_axis_tlast(sl[0]), .s0_axis_tready(s0_tready),
    .s1_axis_tvalid(sv[1]), .s1_axis_tdata(sd[1]), .s1_axis_tkeep(sk[1]),
    .s1_axis_tlast(sl[1]), .s1_axis_tready(s1_tready),
    .m_axis_tx_tready(m_tready), .m_axis_tx_tvalid(m_tvalid), .m_axis_tx_tdata(m_tdata),
    .m_axis_tx_tkeep(m_tkeep), .m_axis_tx_tlast(m_tlast),
    .frame_cnt0(frame_cnt0), .frame_cnt1(frame_cnt1), .oversize_err(oversize_err),
    .o_dbg_state(dbg_state)
  );

  // Beat format in all queues: {tlast, tkeep, tdata}.
  logic [72:0] src_q0[$], src_q1[$];
  logic [72:0] exp_q0[$], exp_q1[$];

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  int mready_pct = 0;

  int          mdl_owner = -1;
  int          mdl_last  = 1;
  int          mdl_beats = 0;
  logic [31:0] mdl_cnt0  = '0;
  logic [31:0] mdl_cnt1  = '0;
  logic        mdl_ovf   = 1'b0;

  int first_v0 = -1, first_m = -1, xfer_cnt = 0, last_tlast_cyc = -1;
  int order_q[$];
  int gap_q[$];
  logic s1_rdy_seen = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic push_frame(input int p, input int n, input logic [7:0] lkeep, input logic [7:0] tag);
    logic [72:0] b;
    for (int i = 0; i < n; i++) begin
      b[72]    = (i == n - 1);
      b[71:64] = (i == n - 1) ? lkeep : 8'hFF;
      b[63:0]  = {8'(p), tag, 16'(i), 32'($urandom)};
      if (p == 0) begin src_q0.push_back(b); exp_q0.push_back(b); end
      else        begin src_q1.push_back(b); exp_q1.push_back(b); end
    end
  endtask

  // Per-cycle compare, scoreboard and model update; sources and m_tready are driven 1 ns after the edge.
  initial begin : cycle_proc
    logic [75:0] e_bus;
    logic m_hs, hs0, hs1, mx, mx_last;
    int nb;
    @(posedge clk156);
    forever begin
      @(negedge clk156);
      cyc_n++;
      e_bus = '0;
      if (!reset && mdl_owner == 0) e_bus = {sv[0], sl[0], sk[0], sd[0], m_tready, 1'b0};
      if (!reset && mdl_owner == 1) e_bus = {sv[1], sl[1], sk[1], sd[1], 1'b0, m_tready};
      check("bus", {m_tvalid, m_tlast, m_tkeep, m_tdata, s0_tready, s1_tready}, e_bus);
      check("counters", {oversize_err, frame_cnt1, frame_cnt0}, {mdl_ovf, mdl_cnt1, mdl_cnt0});
      m_hs = m_tvalid && m_tready;
      if (m_hs) begin
        if (mdl_owner == 0 && exp_q0.size() > 0)      check("beat0", {m_tlast, m_tkeep, m_tdata}, exp_q0.pop_front());
        else if (mdl_owner == 1 && exp_q1.size() > 0) check("beat1", {m_tlast, m_tkeep, m_tdata}, exp_q1.pop_front());
        else check("unexpected_beat", 1, 0);
        xfer_cnt++;
        if (mdl_beats == 0 && last_tlast_cyc >= 0) gap_q.push_back(cyc_n - last_tlast_cyc);
        if (m_tlast) begin order_q.push_back(mdl_owner); last_tlast_cyc = cyc_n; end
      end
      if (sv[0] && first_v0 < 0) first_v0 = cyc_n;
      if (m_tvalid && first_m < 0) first_m = cyc_n;
      if (s1_tready) s1_rdy_seen = 1'b1;
      hs0 = sv[0] && s0_tready;
      hs1 = sv[1] && s1_tready;
      mx  = !reset && mdl_owner >= 0 && sv[mdl_owner] && m_tready;
      mx_last = mx && sl[mdl_owner];
      @(posedge clk156);
      if (reset) begin
        mdl_owner = -1; mdl_last = 1; mdl_beats = 0;
        mdl_cnt0 = '0; mdl_cnt1 = '0; mdl_ovf = 1'b0;
      end else if (mdl_owner < 0) begin
        if (sv[0] && sv[1]) mdl_owner = 1 - mdl_last;
        else if (sv[0])     mdl_owner = 0;
        else if (sv[1])     mdl_owner = 1;
      end else if (mx) begin
        nb = (mdl_beats == 65535) ? 65535 : mdl_beats + 1;
        if (nb > 190) mdl_ovf = 1'b1;
        if (mx_last) begin
          if (mdl_owner == 0) mdl_cnt0 = mdl_cnt0 + 1; else mdl_cnt1 = mdl_cnt1 + 1;
          mdl_last = mdl_owner; mdl_owner = -1; mdl_beats = 0;
        end else mdl_beats = nb;
      end
      #1;
      if (hs0 && src_q0.size() > 0) void'(src_q0.pop_front());
      if (hs1 && src_q1.size() > 0) void'(src_q1.pop_front());
      sv[0] = src_q0.size() > 0;
      {sl[0], sk[0], sd[0]} = sv[0] ? src_q0[0] : 73'd0;
      sv[1] = src_q1.size() > 0;
      {sl[1], sk[1], sd[1]} = sv[1] ? src_q1[0] : 73'd0;
      m_tready = ($urandom_range(99) >= mready_pct);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk156); #2; end
  endtask

  task automatic flush();
    src_q0.delete(); src_q1.delete(); exp_q0.delete(); exp_q1.delete();
  endtask

  task automatic do_reset();
    cyc(1);
    reset = 1'b1;
    flush();
    cyc(1);
    reset = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((src_q0.size() > 0 || src_q1.size() > 0 || mdl_owner >= 0) && k < budget) begin
      cyc(1);
      k++;
    end
    check("idle_timeout", k >= budget, 0);
    cyc(2);
  endtask

  task automatic clear_logs();
    order_q.delete(); gap_q.delete();
    first_v0 = -1; first_m = -1; xfer_cnt = 0; last_tlast_cyc = -1; s1_rdy_seen = 1'b0;
  endtask

  task automatic two_by_two();
    push_frame(0, 8, 8'hFF, 8'h20);
    push_frame(0, 8, 8'h03, 8'h21);
    push_frame(1, 8, 8'h7F, 8'h22);
    push_frame(1, 8, 8'h01, 8'h23);
  endtask

  task automatic check_order_0101();
    check("order_len", order_q.size(), 4);
    if (order_q.size() == 4) begin
      check("order0", order_q[0], 0);
      check("order1", order_q[1], 1);
      check("order2", order_q[2], 0);
      check("order3", order_q[3], 1);
    end
  endtask

  initial begin : stim
    reset = 1'b1;
    m_tready = 1'b1;
    for (int p = 0; p < 2; p++) begin sv[p] = 0; sd[p] = '0; sk[p] = '0; sl[p] = 0; end
    cyc(3);
    reset = 1'b0;
    cyc(2);
    check("reset_counters", {oversize_err, frame_cnt1, frame_cnt0}, 65'd0);
    check("reset_ready", {s0_tready, s1_tready, m_tvalid}, 3'b000);

    // Single 8-beat frame on port 0.
    clear_logs();
    push_frame(0, 8, 8'h0F, 8'h01);
    wait_idle(100);
    check("t1_latency", first_m - first_v0, 1);
    check("t1_beats", xfer_cnt, 8);
    check("t1_cnt0", frame_cnt0, 32'd1);
    check("t1_cnt1", frame_cnt1, 32'd0);
    check("t1_s1_ready", s1_rdy_seen, 1'b0);

    // Both ports continuously valid, MAC always ready.
    do_reset();
    clear_logs();
    two_by_two();
    wait_idle(200);
    check_order_0101();
    check("t2_gaps", gap_q.size(), 3);
    foreach (gap_q[i]) check("t2_gap", gap_q[i], 2);
    check("t2_cnts", {frame_cnt0, frame_cnt1}, {32'd2, 32'd2});

    // Same traffic with 30% MAC backpressure.
    do_reset();
    clear_logs();
    mready_pct = 30;
    two_by_two();
    wait_idle(600);
    mready_pct = 0;
    check_order_0101();
    check("t3_beats", xfer_cnt, 32);
    check("t3_left", exp_q0.size() + exp_q1.size(), 0);
    check("t3_cnts", {frame_cnt0, frame_cnt1}, {32'd2, 32'd2});

    // 190 beats is legal, 191 beats flags oversize.
    do_reset();
    push_frame(0, 190, 8'hFF, 8'h40);
    wait_idle(600);
    check("t4_ovf_190", oversize_err, 1'b0);
    push_frame(1, 191, 8'h0F, 8'h41);
    wait_idle(600);
    check("t4_ovf_191", oversize_err, 1'b1);
    check("t4_cnt1", frame_cnt1, 32'd1);
    cyc(5);
    check("t4_ovf_sticky", oversize_err, 1'b1);

    // One-cycle reset while beat 3 of a port 0 frame is on the bus.
    clear_logs();
    push_frame(0, 8, 8'hFF, 8'h50);
    for (int k = 0; k < 50 && xfer_cnt < 2; k++) cyc(1);
    check("t5_two_beats", xfer_cnt, 2);
    reset = 1'b1;
    flush();
    cyc(1);
    reset = 1'b0;
    @(negedge clk156); #1;
    check("t5_after_reset", {s0_tready, s1_tready, m_tvalid, oversize_err, frame_cnt0, frame_cnt1}, 68'd0);
    push_frame(1, 4, 8'h3F, 8'h51);
    wait_idle(100);
    check("t5_cnts", {frame_cnt0, frame_cnt1}, {32'd0, 32'd1});

    // frame_cnt0 wraps from all-ones to zero.
    @(posedge clk156); #2;
    force dut.r_frame_cnt0 = 32'hFFFF_FFFF;
    mdl_cnt0 = 32'hFFFF_FFFF;
    #1 release dut.r_frame_cnt0;
    cyc(2);
    check("t6_preload", frame_cnt0, 32'hFFFF_FFFF);
    push_frame(0, 2, 8'h01, 8'h60);
    wait_idle(100);
    check("t6_wrap", frame_cnt0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
